sram_1r1w_ctrl: RTL and testbench
=================================

Name: sram_1r1w_ctrl

Overview:
Front-end controller for the 128x512 1R1W SRAM macro (write port 0, read port 1, both on one clock).
- Arbitrates two write requesters onto macro port 0 with round-robin priority.
- Issues reads on port 1 and returns them through a backpressurable response FIFO.
- Resolves same-address read/write collisions.
- Provides a hardware clear sequencer that zero-fills the whole array.

Parameters:
- DATA_WIDTH, 128, word width; matches the macro.
- ADDR_WIDTH, 9, address width; the array has 1<<ADDR_WIDTH words.
- RSP_DEPTH, 3, read-response FIFO entries; also the read credit limit.

Ports:
- clk  in  1  single clock; drives both macro clocks.
- rst  in  1  synchronous, active-high reset.
- clr_start  in  1  pulse: zero-fill the array.
- clr_busy  out  1  high while the clear sequence runs.
- wa_valid / wa_ready / wa_addr / wa_data  in/out/in/in  1/1/ADDR_WIDTH/DATA_WIDTH  write requester A.
- wb_valid / wb_ready / wb_addr / wb_data  in/out/in/in  1/1/ADDR_WIDTH/DATA_WIDTH  write requester B.
- rd_valid / rd_ready / rd_addr  in/out/in  1/1/ADDR_WIDTH  read request.
- rd_rvalid / rd_rready / rd_rdata  out/in/out  1/1/DATA_WIDTH  read response.
- sram_csb0 / sram_addr0 / sram_din0  out  1/ADDR_WIDTH/DATA_WIDTH  macro port 0; csb is active low.
- sram_csb1 / sram_addr1  out  1/ADDR_WIDTH  macro port 1.
- sram_dout1  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset values: state RUN, rr pointer = A, s1 stage empty, FIFO empty, clear counter 0, clr_busy 0, rd_rvalid 0, sram_csb0/csb1 = 1, rd_rdata 0.
- Macro pins are driven combinationally from the accepted handshake. The macro samples them on the same rising edge as the handshake.
- Writes:
  - A request is granted when the state is RUN.
  - If both A and B are valid, the rr pointer decides the grant; after the grant the pointer moves to the other requester.
  - A single valid requester is always granted.
  - Exactly one ready is high per grant. Writes are fire-and-forget, latency 0.
  - The pointer changes only on a two-way contest.
- Reads:
  - rd_ready = RUN & (s1_valid + fifo_count < RSP_DEPTH) & no stalling collision.
  - A read accepted in cycle N sets s1_valid in N+1. In N+1, sram_dout1 is pushed into the FIFO.
  - rd_rvalid is therefore earliest in N+2.
  - Steady-state throughput is 1 read/cycle with rd_rready held high.
  - FIFO pop on rd_rvalid & rd_rready; a push and a pop may occur in the same cycle.
  - rd_rdata and rd_rvalid hold stable while stalled.
- Collision: a write granted and a read accepted in the same cycle to the same address.
  - Without the optional feature: rd_ready drops that cycle, so the read retries next cycle after the write has landed.
  - A write in N-1 and a read in N to the same address needs no action.
- Clear FSM (RUN/CLEAR):
  - clr_start in RUN enters CLEAR.
  - CLEAR writes 0 to address = counter, one per cycle, counting 0 to 511, then returns to RUN. Duration is exactly 512 cycles.
  - During CLEAR, wa_ready, wb_ready and rd_ready are 0; in-flight reads drain normally.
  - clr_start while in CLEAR is ignored.
- Reset mid-clear aborts the sequence: state RUN, csb high, and the array is left partially cleared.

Optional Feature:
- Macro: SRAM_CTRL_FWD_EN.
- Defined: a colliding read is accepted instead of stalled. s1 carries a fwd flag plus the write data, and the FIFO pushes the forwarded data instead of sram_dout1. The response equals the new write data.
- Undefined: stall behaviour as described under Behaviour; no forwarding storage.

Decomposition:
- Package sram_ctrl_pkg holds:
  - DATA_WIDTH/ADDR_WIDTH defaults;
  - the state enum {ST_RUN, ST_CLEAR};
  - the s1 stage struct {valid, fwd, fwd_data};
  - a write-grant enum {GNT_NONE, GNT_A, GNT_B}.
- Sub-module sram_rsp_fifo: a parameterised synchronous FIFO with depth RSP_DEPTH, count output, same-cycle push/pop.

Test Plan:
1. Reset, then A writes 0x5 -> addr 3; read addr 3 in a later cycle -> rd_rvalid 2 cycles after acceptance, rd_rdata = 0x5.
2. wa and wb valid together for 4 cycles (A addr 10..13, B addr 20..23) -> grants alternate A,B,A,B; each requester holds until served; all 8 words read back correctly.
3. 16 back-to-back reads with rd_rready = 1 -> rd_ready never drops, 16 consecutive responses. Then rd_rready = 0 -> rd_ready drops after 3 outstanding, with no loss or reordering after release.
4. Write 0xAA and read addr 7 in the same cycle:
   - without SRAM_CTRL_FWD_EN -> rd_ready = 0 for that cycle, response 0xAA one cycle later;
   - with SRAM_CTRL_FWD_EN -> accepted immediately, response 0xAA.
5. Fill addrs 0/255/511 with nonzero data, pulse clr_start -> clr_busy high exactly 512 cycles, all readies low; reads of 0/255/511 then return 0.
6. Assert rst at clear cycle 100 -> clr_busy 0 and csb0 = 1 next cycle; addr 99 reads 0; addr 300 keeps its prior data.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the 1R1W SRAM front-end controller.
// Build option: SRAM_CTRL_FWD_EN enables write-to-read forwarding on collisions.
package sram_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_ADDR_WIDTH = 9;

    // RUN serves requesters; CLEAR owns port 0 while zero-filling the array.
    typedef enum logic {
        ST_RUN,
        ST_CLEAR
    } state_t;

    // Which requester owns macro port 0 this cycle.
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_A,
        GNT_B
    } gnt_t;

    // Read pipeline stage between macro access and response FIFO push.
    typedef struct packed {
        logic                      valid;
        logic                      fwd;
        logic [DEF_DATA_WIDTH-1:0] fwd_data;
    } s1_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO with occupancy count and same-cycle push/pop.
// Head data reads as zero while empty so the response bus is clean after reset.
module sram_rsp_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 3,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0]      count,
    output logic                  not_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop    = pop && (count_q != '0);
    assign do_push   = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    assign not_empty = (count_q != '0);
    assign count     = count_q;
    assign pop_data  = not_empty ? mem[rd_ptr_q] : '0;

    // Storage write; entries carry no reset value.
    // NOTE: data storage is deliberately not reset; only pointers and count are, and empty reads are masked.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_1r1w_ctrl.sv
// Front-end controller for a 1R1W SRAM macro: round-robin write arbitration on
// port 0, credited reads on port 1 with a response FIFO, collision handling and
// a zero-fill clear sequencer.
// Build option: SRAM_CTRL_FWD_EN -- colliding reads are forwarded instead of stalled.
module sram_1r1w_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RSP_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_start,
    output logic                  clr_busy,
    input  logic                  wa_valid,
    output logic                  wa_ready,
    input  logic [ADDR_WIDTH-1:0] wa_addr,
    input  logic [DATA_WIDTH-1:0] wa_data,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_rvalid,
    input  logic                  rd_rready,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  rr_b_q;
    gnt_t                  gnt;
    logic                  run;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  collide;
    logic                  credit_ok;
    logic                  rd_fire;
    logic [CNT_W-1:0]      fifo_count;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] push_data;

    assign run      = (state_q == ST_RUN);
    assign clr_busy = (state_q == ST_CLEAR);

    // Clear sequencer state and address counter.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Clear sequencer next state: one zero write per cycle over the whole array.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (clr_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == '1) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Write arbitration: lone requester always wins, contests follow the rr pointer.
    always_comb begin
        gnt = GNT_NONE;
        if (run) begin
            if (wa_valid && wb_valid) gnt = rr_b_q ? GNT_B : GNT_A;
            else if (wa_valid)        gnt = GNT_A;
            else if (wb_valid)        gnt = GNT_B;
        end
    end

    // Round-robin pointer moves only after a two-way contest.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_b_q <= 1'b0;
        end else if (run && wa_valid && wb_valid) begin
            rr_b_q <= (gnt == GNT_A);
        end
    end

    assign wa_ready = (gnt == GNT_A);
    assign wb_ready = (gnt == GNT_B);
    assign wr_addr  = (gnt == GNT_B) ? wb_addr : wa_addr;
    assign wr_data  = (gnt == GNT_B) ? wb_data : wa_data;

    // Read acceptance: credits cover both the s1 stage and FIFO occupancy.
    assign collide   = (gnt != GNT_NONE) && rd_valid && (rd_addr == wr_addr);
    assign credit_ok = ((CNT_W+1)'(s1_valid) + (CNT_W+1)'(fifo_count)) < (CNT_W+1)'(RSP_DEPTH);
`ifdef SRAM_CTRL_FWD_EN
    assign rd_ready  = run && credit_ok;
`else
    assign rd_ready  = run && credit_ok && !collide;
`endif
    assign rd_fire   = rd_valid && rd_ready;

    // Macro port 0: clear sequencer has priority, otherwise the granted write.
    always_comb begin
        sram_csb0  = 1'b1;
        sram_addr0 = wr_addr;
        sram_din0  = wr_data;
        if (clr_busy) begin
            sram_csb0  = 1'b0;
            sram_addr0 = clr_cnt_q;
            sram_din0  = '0;
        end else if (gnt != GNT_NONE) begin
            sram_csb0  = 1'b0;
        end
    end

    assign sram_csb1  = !rd_fire;
    assign sram_addr1 = rd_addr;

`ifdef SRAM_CTRL_FWD_EN
    s1_t s1_q;

    // s1 stage: remembers whether the macro data must be replaced by write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
        end else begin
            s1_q.valid <= rd_fire;
            s1_q.fwd   <= rd_fire && collide;
            if (rd_fire && collide) s1_q.fwd_data <= wr_data;
        end
    end

    assign s1_valid  = s1_q.valid;
    assign push_data = s1_q.fwd ? s1_q.fwd_data : sram_dout1;
`else
    logic s1_valid_q;

    // s1 stage: marks the cycle the macro read data is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_fire;
        end
    end

    assign s1_valid  = s1_valid_q;
    assign push_data = sram_dout1;
`endif

    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH),
        .CNT_W      (CNT_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid),
        .push_data (push_data),
        .pop       (rd_rvalid && rd_rready),
        .pop_data  (rd_rdata),
        .count     (fifo_count),
        .not_empty (rd_rvalid)
    );

endmodule

// File: tb/tb_sram_1r1w_ctrl.sv
// Self-checking bench for sram_1r1w_ctrl with a behavioural 1R1W macro,
// a reference memory and a response scoreboard.
module tb_sram_1r1w_ctrl;

    localparam int DW    = 128;
    localparam int AW    = 9;
    localparam int WORDS = 1 << AW;
`ifdef SRAM_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_start;
    logic          clr_busy;
    logic          wa_valid, wa_ready;
    logic [AW-1:0] wa_addr;
    logic [DW-1:0] wa_data;
    logic          wb_valid, wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          rd_valid, rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_rvalid, rd_rready;
    logic [DW-1:0] rd_rdata;
    logic          sram_csb0, sram_csb1;
    logic [AW-1:0] sram_addr0, sram_addr1;
    logic [DW-1:0] sram_din0, sram_dout1;

    always #5 clk = ~clk;

    sram_1r1w_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(3)) dut (
        .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy),
        .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_rvalid(rd_rvalid), .rd_rready(rd_rready), .rd_rdata(rd_rdata),
        .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    // Behavioural macro: synchronous write on port 0, registered read on port 1.
    logic [DW-1:0] macro_mem [WORDS];
    always @(posedge clk) begin
        if (!sram_csb0) macro_mem[sram_addr0] <= sram_din0;
        if (!sram_csb1) sram_dout1 <= macro_mem[sram_addr1];
    end

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    logic [DW-1:0] ref_mem [WORDS];
    logic [DW-1:0] exp_q [$];
    int            resp_cyc [$];
    bit            ref_clr_active = 1'b0;
    int            ref_clr_cnt = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and scoreboard, evaluated mid-cycle ahead of each handshake edge.
    always @(negedge clk) begin
        logic [DW-1:0] exp;
        if (rst) begin
            if (ref_clr_active) ref_mem[ref_clr_cnt] = '0;
            ref_clr_active = 1'b0;
        end else begin
            if (ref_clr_active) begin
                ref_mem[ref_clr_cnt] = '0;
                if (ref_clr_cnt == WORDS - 1) ref_clr_active = 1'b0;
                else ref_clr_cnt++;
            end else if (clr_start) begin
                ref_clr_active = 1'b1;
                ref_clr_cnt    = 0;
            end
            if (wa_valid && wa_ready) ref_mem[wa_addr] = wa_data;
            if (wb_valid && wb_ready) ref_mem[wb_addr] = wb_data;
            if (rd_valid && rd_ready) exp_q.push_back(ref_mem[rd_addr]);
            if (rd_rvalid && rd_rready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_expected", DW'(exp_q.size()), DW'(1));
                end else begin
                    exp = exp_q.pop_front();
                    check("rsp_data", rd_rdata, exp);
                    resp_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_port(input bit use_b, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit done = 1'b0;
        if (use_b) begin wb_valid = 1'b1; wb_addr = a; wb_data = d; end
        else       begin wa_valid = 1'b1; wa_addr = a; wa_data = d; end
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = use_b ? wb_ready : wa_ready;
            @(posedge clk); #1;
        end
        wa_valid = 1'b0;
        wb_valid = 1'b0;
        if (!done) check("write_timeout", DW'(done), DW'(1));
    endtask

    task automatic read_one(input logic [AW-1:0] a, output int acc_cyc);
        bit done = 1'b0;
        acc_cyc  = 0;
        rd_valid = 1'b1;
        rd_addr  = a;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done    = rd_ready;
            acc_cyc = cyc;
            @(posedge clk); #1;
        end
        rd_valid = 1'b0;
        if (!done) check("read_timeout", DW'(done), DW'(1));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain", DW'(exp_q.size()), DW'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int            t0;
        int            idx;
        int            drops;
        int            n;
        bit            rdy;
        bit            bad;
        bit            have;
        logic [DW-1:0] held;
        logic [AW-1:0] seq [16];
        logic [AW-1:0] bp  [6];

        for (int i = 0; i < WORDS; i++) begin
            macro_mem[i] = {4{32'hC0DE_0000 | i}};
            ref_mem[i]   = {4{32'hC0DE_0000 | i}};
        end
        rst = 1'b1; clr_start = 1'b0;
        wa_valid = 1'b0; wa_addr = '0; wa_data = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        rd_valid = 1'b0; rd_addr = '0; rd_rready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_clr_busy", DW'(clr_busy), DW'(0));
        check("rst_rvalid",   DW'(rd_rvalid), DW'(0));
        check("rst_rdata",    rd_rdata, DW'(0));
        check("rst_csb0",     DW'(sram_csb0), DW'(1));
        check("rst_csb1",     DW'(sram_csb1), DW'(1));
        @(posedge clk); #1;

        // 1: single write then read, latency 2.
        write_port(1'b0, AW'(3), DW'(5));
        @(posedge clk); #1;
        read_one(AW'(3), t0);
        wait_drain();
        check("rd_latency", DW'(resp_cyc[resp_cyc.size()-1] - t0), DW'(2));

        // 2: contested writes alternate A,B,...
        wa_valid = 1'b1; wa_addr = AW'(10); wa_data = DW'('hA0);
        wb_valid = 1'b1; wb_addr = AW'(20); wb_data = DW'('hB0);
        idx = 0;
        for (int c = 0; c < 20 && idx < 8; c++) begin
            @(negedge clk);
            check("arb_onehot", DW'(int'(wa_ready) + int'(wb_ready)), DW'(1));
            check("arb_order_b", DW'(wb_ready), DW'(idx % 2));
            rdy = wa_ready;
            @(posedge clk); #1;
            idx++;
            if (rdy) begin
                if (wa_addr == AW'(13)) wa_valid = 1'b0;
                else begin wa_addr = wa_addr + 1'b1; wa_data = wa_data + 1'b1; end
            end else begin
                if (wb_addr == AW'(23)) wb_valid = 1'b0;
                else begin wb_addr = wb_addr + 1'b1; wb_data = wb_data + 1'b1; end
            end
        end
        wa_valid = 1'b0; wb_valid = 1'b0;
        check("arb_grants", DW'(idx), DW'(8));

        // 3a: 16 back-to-back reads with the response side open.
        for (int i = 0; i < 16; i++) seq[i] = AW'(((i % 2) != 0 ? 20 : 10) + ((i / 2) % 4));
        idx = 0; drops = 0;
        rd_valid = 1'b1; rd_addr = seq[0];
        for (int c = 0; c < 100 && idx < 16; c++) begin
            @(negedge clk);
            rdy = rd_ready;
            if (!rdy) drops++;
            @(posedge clk); #1;
            if (rdy) begin
                idx++;
                if (idx < 16) rd_addr = seq[idx];
            end
        end
        rd_valid = 1'b0;
        check("b2b_count", DW'(idx), DW'(16));
        check("b2b_drops", DW'(drops), DW'(0));
        wait_drain();
        n = resp_cyc.size();
        check("b2b_consecutive", DW'(resp_cyc[n-1] - resp_cyc[n-16]), DW'(15));

        // 3b: backpressure limits outstanding reads to the credit depth.
        bp[0] = AW'(10); bp[1] = AW'(20); bp[2] = AW'(11);
        bp[3] = AW'(21); bp[4] = AW'(12); bp[5] = AW'(22);
        rd_rready = 1'b0;
        idx = 0; have = 1'b0; held = '0;
        rd_valid = 1'b1; rd_addr = bp[0];
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rdy = rd_ready;
            if (rd_rvalid) begin
                if (have) check("stall_hold", rd_rdata, held);
                else begin held = rd_rdata; have = 1'b1; end
            end
            @(posedge clk); #1;
            if (rdy) begin idx++; rd_addr = bp[idx]; end
        end
        check("bp_accepts", DW'(idx), DW'(3));
        check("bp_rvalid", DW'(have), DW'(1));
        rd_rready = 1'b1;
        for (int c = 0; c < 30 && idx < 6; c++) begin
            @(negedge clk);
            rdy = rd_ready;
            @(posedge clk); #1;
            if (rdy) begin
                idx++;
                if (idx < 6) rd_addr = bp[idx];
            end
        end
        rd_valid = 1'b0;
        check("bp_total", DW'(idx), DW'(6));
        wait_drain();

        // 4: same-cycle write and read to one address.
        wa_valid = 1'b1; wa_addr = AW'(7); wa_data = DW'('hAA);
        rd_valid = 1'b1; rd_addr = AW'(7);
        @(negedge clk);
        check("coll_wr_ready", DW'(wa_ready), DW'(1));
        check("coll_rd_ready", DW'(rd_ready), DW'(FWD));
        t0 = cyc;
        @(posedge clk); #1;
        wa_valid = 1'b0;
        if (!FWD) begin
            @(negedge clk);
            check("coll_retry_ready", DW'(rd_ready), DW'(1));
            @(posedge clk); #1;
        end
        rd_valid = 1'b0;
        wait_drain();
        check("coll_latency", DW'(resp_cyc[resp_cyc.size()-1] - t0), DW'(FWD ? 2 : 3));

        // 5: full clear.
        write_port(1'b1, AW'(0),   DW'('h1111));
        write_port(1'b1, AW'(255), DW'('h2222));
        write_port(1'b1, AW'(511), DW'('h3333));
        read_one(AW'(0), t0);
        read_one(AW'(255), t0);
        read_one(AW'(511), t0);
        wait_drain();
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        wa_valid = 1'b1; wa_addr = AW'(100); wa_data = DW'('h1234);
        wb_valid = 1'b1; wb_addr = AW'(101); wb_data = DW'('h5678);
        rd_valid = 1'b1; rd_addr = AW'(5);
        n = 0; bad = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (!clr_busy) break;
            n++;
            if (wa_ready || wb_ready || rd_ready) bad = 1'b1;
        end
        @(posedge clk); #1;
        wa_valid = 1'b0; wb_valid = 1'b0; rd_valid = 1'b0;
        check("clr_cycles", DW'(n), DW'(512));
        check("clr_readies_low", DW'(bad), DW'(0));
        read_one(AW'(0), t0);
        read_one(AW'(255), t0);
        read_one(AW'(511), t0);
        read_one(AW'(100), t0);
        wait_drain();

        // 6: reset aborts the clear partway.
        write_port(1'b0, AW'(99),  DW'('h9999));
        write_port(1'b0, AW'(300), DW'('h3000_0300));
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_clr_busy", DW'(clr_busy), DW'(0));
        check("abort_csb0", DW'(sram_csb0), DW'(1));
        @(posedge clk); #1;
        read_one(AW'(99), t0);
        read_one(AW'(300), t0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
